stopwatch_watch_ctrl: RTL and testbench
=======================================

# stopwatch_watch_ctrl

Button-driven controller that sequences the stopwatch and watch datapaths of the top-level timekeeping design. It converts the four pushbutton levels, the mode-select switch and the edit switch into the stopwatch run/stop level, a one-cycle clear pulse, and per-field up/down edit pulses for the watch counters. It sits between the button debouncers and the two datapaths and also drives the four status LEDs.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000 — cycles btn_u/btn_d must be held before auto-repeat starts (only with AUTO_REPEAT_EN).
- `REPEAT_CYCLES`, default 10_000_000 — cycles between auto-repeat pulses (only with AUTO_REPEAT_EN).

Ports:
- `clk` input 1 — system clock.
- `reset` input 1 — synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `btn_u`, `btn_d`, `btn_r`, `btn_l` input 1 each — debounced button levels, high = pressed.
- `watch_select` input 1 — 0 = watch mode, 1 = stopwatch mode.
- `edit_en` input 1 — watch edit-mode switch.
- `run_stop` output 1 — stopwatch run level to the stopwatch datapath.
- `clear` output 1 — one-cycle stopwatch clear pulse.
- `edit_msec`, `edit_sec`, `edit_min`, `edit_hour` output 2 each — 2'b01 = increment, 2'b11 = decrement, 2'b00 = none; one-cycle pulses.
- `LED` output 4 — status indicator.

## Operation
- Edge detect: each button is registered once; press event = btn & ~btn_q. Only press events act, never levels. The exception is auto-repeat.
- The edit-active condition is `watch_select==0 && edit_en==1`. The stopwatch-active condition is `watch_select==1`. When a condition is inactive, its buttons are ignored.
- Stopwatch FSM has three states: STOP, RUN, CLR.
  - In STOP: btn_r goes to RUN. btn_l goes to CLR.
  - In RUN: btn_r goes to STOP. btn_l is ignored.
  - CLR lasts exactly one cycle, then returns to STOP.
  - If btn_r and btn_l are pressed in the same cycle, btn_r wins and btn_l is dropped.
- Stopwatch outputs: run_stop = (state==RUN). clear = (state==CLR).
- The FSM state is retained across mode switches, so the stopwatch keeps running in watch mode.
- Field pointer is 2 bits: 0 = msec, 1 = sec, 2 = min, 3 = hour.
  - btn_l increments the pointer, wrapping 3→0.
  - btn_r decrements the pointer, wrapping 0→3.
  - If btn_l and btn_r are pressed together, neither moves the pointer.
  - The pointer is forced to 0 whenever edit-active is false.
- Value edit: btn_u emits 2'b01 on the selected field's edit output. btn_d emits 2'b11. All other edit outputs stay 2'b00.
  - btn_u has priority over btn_d.
  - If a value edit and a pointer move occur in the same cycle, the edit applies to the current field and the move is discarded.
- LED:
  - When edit is active: one-hot of the pointer (LED[0] = msec … LED[3] = hour).
  - In stopwatch mode: {2'b10, CLR, RUN}.
  - Otherwise: 4'b0000.

## Timing
- Reset values: run_stop=0, clear=0, all edit_* = 2'b00, LED=4'b0000, FSM=STOP, pointer=0, btn_q=0, repeat counter=0.
- All outputs are registered. Latency is 1 clock: a button that is high at edge k (and low at edge k-1) produces an output change visible after edge k. Edit pulses and clear are exactly one cycle wide.
- A button already high when reset is released produces no event until it is released and pressed again. This is because btn_q is loaded with the live level during the first post-reset cycle.
- A mode or edit_en change takes effect on the same edge. An edge that coincides with deactivation is dropped.
- A synchronous reset during CLR or RUN returns to STOP on that edge, with no clear pulse.

## Configuration
- `STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN`
- **Defined:**
  - While edit is active and btn_u (or btn_d) is held continuously, a counter runs from the press event.
  - After HOLD_CYCLES it emits a repeat pulse, then one more every REPEAT_CYCLES.
  - Each repeat pulse is identical to a press pulse on the current field.
  - Releasing the button, pressing the other of btn_u/btn_d, or leaving edit mode clears the counter.
- **Undefined:** there is no repeat logic and the parameters are unused. One pulse is produced per press.

## Test plan
- Stopwatch toggling: reset, watch_select=1, pulse btn_r → run_stop=1 one cycle later and LED=4'b1001. Pulse btn_r again → run_stop=0.
- Clear: in STOP, press btn_l → clear=1 for exactly one cycle and LED=4'b1010 that cycle. In RUN, btn_l → clear stays 0.
- Field select: watch_select=0, edit_en=1, btn_l ×4 → LED steps 0010, 0100, 1000, 0001. btn_r from 0001 → 1000.
- Edit pulses: pointer=2, hold btn_u 20 cycles (macro off) → edit_min=2'b01 for one cycle only. btn_d → edit_min=2'b11, others 2'b00. Press btn_u and btn_d together → only 2'b01.
- Gating/priority: btn_u with edit_en=0 → no edit pulse and LED=0000. btn_r+btn_l together in stopwatch STOP → RUN, no clear.
- Auto-repeat (macro on, HOLD_CYCLES=10, REPEAT_CYCLES=4): hold btn_u 30 cycles → pulses at press+1, +11, +15, +19, +23, +27. Release → no further pulses.

Source files
------------

// File: rtl/stopwatch_watch_ctrl.sv
// Purpose: pushbutton/switch controller for the stopwatch run/clear FSM and watch field editing, plus status LEDs.
// Latency: one clock from a button press edge to registered outputs (run_stop, clear, edit_*, LED).
// Backpressure: none; inputs are debounced levels and every output is a level or a one-cycle pulse.
// Optional auto-repeat on held btn_u/btn_d is built when STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN is defined.
module stopwatch_watch_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_r,
    input  logic       btn_l,
    input  logic       watch_select,
    input  logic       edit_en,
    output logic       run_stop,
    output logic       clear,
    output logic [1:0] edit_msec,
    output logic [1:0] edit_sec,
    output logic [1:0] edit_min,
    output logic [1:0] edit_hour,
    output logic [3:0] LED
);

    // Encoding keeps RUN and CLR on separate bits so the outputs are plain register bits.
    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_CLR  = 2'b10
    } sw_state_t;

    // Button history {l, r, d, u}; armed_q masks events on the first cycle after reset
    // so a button held through reset must be released and pressed again.
    logic [3:0] btn_q;
    logic       armed_q;
    logic [3:0] btn_now;
    logic [3:0] press;
    logic       ev_u, ev_d, ev_r, ev_l;
    logic       sw_act, ed_act;

    sw_state_t  state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0][1:0] edit_q, edit_d;
    logic [3:0] led_q, led_d;

    // Value-edit requests: a press event or an auto-repeat tick.
    logic       rep_u, rep_d;
    logic       val_u, val_d;

    assign btn_now = {btn_l, btn_r, btn_d, btn_u};
    assign press   = armed_q ? (btn_now & ~btn_q) : 4'b0000;
    assign ev_u    = press[0];
    assign ev_d    = press[1];
    assign ev_r    = press[2];
    assign ev_l    = press[3];

    assign sw_act  = watch_select;
    assign ed_act  = ~watch_select & edit_en;

    assign val_u   = ev_u | rep_u;
    assign val_d   = ev_d | rep_d;

    // Button history registers used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q   <= 4'b0000;
            armed_q <= 1'b0;
        end else begin
            btn_q   <= btn_now;
            armed_q <= 1'b1;
        end
    end

    // Stopwatch FSM state register; reset lands in STOP without a clear pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Stopwatch next state: btn_r toggles run/stop and wins over btn_l; btn_l clears only from STOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (sw_act && ev_r) begin
                    state_d = ST_RUN;
                end else if (sw_act && ev_l) begin
                    state_d = ST_CLR;
                end
            end
            ST_RUN: begin
                if (sw_act && ev_r) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLR:  state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    // Stopwatch outputs decoded straight from the state register bits.
    always_comb begin
        run_stop = (state_q == ST_RUN);
        clear    = (state_q == ST_CLR);
    end

    // Field pointer: l/r move it with wrap, a simultaneous value edit freezes it, leaving edit mode zeroes it.
    always_comb begin
        ptr_d = ptr_q;
        if (!ed_act) begin
            ptr_d = 2'd0;
        end else if (!(val_u || val_d)) begin
            if (ev_l && !ev_r) begin
                ptr_d = ptr_q + 2'd1;
            end else if (ev_r && !ev_l) begin
                ptr_d = ptr_q - 2'd1;
            end
        end
    end

    // Edit pulses target the field selected before any same-cycle pointer move; up beats down.
    always_comb begin
        edit_d = '0;
        if (ed_act) begin
            if (val_u) begin
                edit_d[ptr_q] = 2'b01;
            end else if (val_d) begin
                edit_d[ptr_q] = 2'b11;
            end
        end
    end

    // LED reflects the state as it will be after this edge, so it changes together with the outputs it describes.
    always_comb begin
        led_d = 4'b0000;
        if (ed_act) begin
            led_d = 4'b0001 << ptr_d;
        end else if (sw_act) begin
            led_d = {2'b10, (state_d == ST_CLR), (state_d == ST_RUN)};
        end
    end

    // Pointer, edit pulse and LED registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= 2'd0;
            edit_q <= '0;
            led_q  <= 4'b0000;
        end else begin
            ptr_q  <= ptr_d;
            edit_q <= edit_d;
            led_q  <= led_d;
        end
    end

    assign edit_msec = edit_q[0];
    assign edit_sec  = edit_q[1];
    assign edit_min  = edit_q[2];
    assign edit_hour = edit_q[3];
    assign LED       = led_q;

`ifdef STOPWATCH_WATCH_CTRL_AUTO_REPEAT_EN
    // Auto-repeat tracker: counts down from the press event, fires after HOLD_CYCLES, then every REPEAT_CYCLES.
    logic        rep_act_q, rep_act_d;
    logic        rep_is_d_q, rep_is_d_d;
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_fire;

    // Repeat next state: a new press restarts tracking, release or leaving edit mode cancels it.
    always_comb begin
        rep_act_d  = rep_act_q;
        rep_is_d_d = rep_is_d_q;
        rep_cnt_d  = rep_cnt_q;
        rep_fire   = 1'b0;
        if (!ed_act) begin
            rep_act_d = 1'b0;
            rep_cnt_d = 32'd0;
        end else if (ev_u) begin
            rep_act_d  = 1'b1;
            rep_is_d_d = 1'b0;
            rep_cnt_d  = HOLD_CYCLES - 32'd1;
        end else if (ev_d) begin
            rep_act_d  = 1'b1;
            rep_is_d_d = 1'b1;
            rep_cnt_d  = HOLD_CYCLES - 32'd1;
        end else if (rep_act_q && (rep_is_d_q ? btn_d : btn_u)) begin
            if (rep_cnt_q == 32'd0) begin
                rep_fire  = 1'b1;
                rep_cnt_d = REPEAT_CYCLES - 32'd1;
            end else begin
                rep_cnt_d = rep_cnt_q - 32'd1;
            end
        end else begin
            rep_act_d = 1'b0;
            rep_cnt_d = 32'd0;
        end
    end

    // Repeat tracker registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_act_q  <= 1'b0;
            rep_is_d_q <= 1'b0;
            rep_cnt_q  <= 32'd0;
        end else begin
            rep_act_q  <= rep_act_d;
            rep_is_d_q <= rep_is_d_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign rep_u = rep_fire & ~rep_is_d_q;
    assign rep_d = rep_fire &  rep_is_d_q;
`else
    // Without auto-repeat only press events edit; the timing parameters are deliberately inert.
    logic unused_params;
    assign unused_params = ^{HOLD_CYCLES, REPEAT_CYCLES};
    assign rep_u = 1'b0;
    assign rep_d = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_watch_ctrl.sv
// Bench for stopwatch_watch_ctrl (default build): directed steps then random levels, against a behavioural model.
module tb_stopwatch_watch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_u, btn_d, btn_r, btn_l;
    logic       watch_select, edit_en;
    logic       run_stop, clear;
    logic [1:0] edit_msec, edit_sec, edit_min, edit_hour;
    logic [3:0] LED;

    always #5 clk = ~clk;

    stopwatch_watch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .btn_u        (btn_u),
        .btn_d        (btn_d),
        .btn_r        (btn_r),
        .btn_l        (btn_l),
        .watch_select (watch_select),
        .edit_en      (edit_en),
        .run_stop     (run_stop),
        .clear        (clear),
        .edit_msec    (edit_msec),
        .edit_sec     (edit_sec),
        .edit_min     (edit_min),
        .edit_hour    (edit_hour),
        .LED          (LED)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Model: stopwatch is "running" plus a one-cycle "clearing" flag; field is a plain 0..3 index.
    bit         m_run, m_clr, m_armed;
    int         m_fld;
    bit   [3:0] m_prev;
    logic [7:0] m_edit;
    logic [3:0] m_led;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input bit u, input bit d, input bit r, input bit l,
                              input bit ws, input bit ee);
        bit pu, pd, pr, pl, swa, eda, was_clr;
        if (rs) begin
            m_run = 0; m_clr = 0; m_fld = 0; m_prev = 4'b0; m_armed = 0;
            m_edit = 8'h00; m_led = 4'h0;
        end else begin
            pu = m_armed && u && !m_prev[0];
            pd = m_armed && d && !m_prev[1];
            pr = m_armed && r && !m_prev[2];
            pl = m_armed && l && !m_prev[3];
            m_prev  = {l, r, d, u};
            m_armed = 1;
            swa = ws;
            eda = !ws && ee;
            was_clr = m_clr;
            m_clr = 0;
            if (!was_clr && swa) begin
                if (pr) m_run = !m_run;
                else if (pl && !m_run) m_clr = 1;
            end
            m_edit = 8'h00;
            if (eda) begin
                if (pu) m_edit = 8'(1 << (2 * m_fld));
                else if (pd) m_edit = 8'(3 << (2 * m_fld));
                else if (pl && !pr) m_fld = (m_fld + 1) % 4;
                else if (pr && !pl) m_fld = (m_fld + 3) % 4;
            end else begin
                m_fld = 0;
            end
            if (eda) m_led = 4'(1 << m_fld);
            else if (swa) m_led = {2'b10, m_clr, m_run};
            else m_led = 4'b0000;
        end
    endtask

    // One clock: drive inputs, let the edge happen, step the model, compare every output.
    task automatic tick(input bit rs, input bit u, input bit d, input bit r, input bit l,
                        input bit ws, input bit ee);
        reset = rs; btn_u = u; btn_d = d; btn_r = r; btn_l = l;
        watch_select = ws; edit_en = ee;
        @(posedge clk);
        model_edge(rs, u, d, r, l, ws, ee);
        #1;
        check("run_stop", 8'(run_stop), 8'(m_run));
        check("clear", 8'(clear), 8'(m_clr));
        check("edit", {edit_hour, edit_min, edit_sec, edit_msec}, m_edit);
        check("led", 8'(LED), 8'(m_led));
    endtask

    initial begin
        logic [3:0] led_seq [4];
        int  npulse;
        bit  ru, rd, rr, rl, rws, ree, rrs;

        led_seq[0] = 4'b0010; led_seq[1] = 4'b0100; led_seq[2] = 4'b1000; led_seq[3] = 4'b0001;

        // Reset state
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        check("rst_led", 8'(LED), 8'h00);
        check("rst_run", 8'(run_stop), 8'h00);
        check("rst_edit", {edit_hour, edit_min, edit_sec, edit_msec}, 8'h00);

        // btn_r held through reset release must not start the stopwatch
        tick(1, 0, 0, 1, 0, 1, 0);
        tick(0, 0, 0, 1, 0, 1, 0);
        tick(0, 0, 0, 1, 0, 1, 0);
        check("held_thru_reset_run", 8'(run_stop), 8'h00);
        check("held_thru_reset_led", 8'(LED), 8'h08);
        tick(0, 0, 0, 0, 0, 1, 0);

        // Start / stop toggling
        tick(0, 0, 0, 1, 0, 1, 0);
        check("start_run", 8'(run_stop), 8'h01);
        check("start_led", 8'(LED), 8'h09);
        tick(0, 0, 0, 1, 0, 1, 0);
        check("held_r_still_run", 8'(run_stop), 8'h01);
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0, 1, 0);
        check("stop_run", 8'(run_stop), 8'h00);
        tick(0, 0, 0, 0, 0, 1, 0);

        // Clear from STOP: one cycle only
        tick(0, 0, 0, 0, 1, 1, 0);
        check("clear_pulse", 8'(clear), 8'h01);
        check("clear_led", 8'(LED), 8'h0A);
        tick(0, 0, 0, 0, 1, 1, 0);
        check("clear_one_cycle", 8'(clear), 8'h00);
        tick(0, 0, 0, 0, 0, 1, 0);

        // btn_l ignored while running
        tick(0, 0, 0, 1, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 1, 0);
        check("run_l_no_clear", 8'(clear), 8'h00);
        check("run_l_still_run", 8'(run_stop), 8'h01);
        tick(0, 0, 0, 0, 0, 1, 0);

        // Reset while running returns to STOP silently
        tick(1, 0, 0, 0, 0, 1, 0);
        check("rst_in_run", {6'b0, run_stop, clear}, 8'h00);
        tick(0, 0, 0, 0, 0, 1, 0);

        // Field select in edit mode
        tick(0, 0, 0, 0, 0, 0, 1);
        check("edit_idle_led", 8'(LED), 8'h01);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 1, 0, 1);
            check("field_l_step", 8'(LED), 8'(led_seq[i]));
            tick(0, 0, 0, 0, 0, 0, 1);
        end
        tick(0, 0, 0, 1, 0, 0, 1);
        check("field_r_wrap", 8'(LED), 8'h08);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 0, 1);
        check("field_min", 8'(LED), 8'h04);
        tick(0, 0, 0, 0, 0, 0, 1);

        // Held btn_u gives a single increment pulse
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 0, 0, 0, 1);
            if (edit_min == 2'b01) npulse++;
        end
        check("u_hold_one_pulse", 8'(npulse), 8'h01);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 0, 0, 1);
        check("d_min", 8'(edit_min), 8'h03);
        check("d_others", {2'b00, edit_hour, edit_sec, edit_msec}, 8'h00);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 0, 1);
        check("ud_u_wins", 8'(edit_min), 8'h01);
        tick(0, 0, 0, 0, 0, 0, 1);

        // Edit plus pointer move: edit wins, pointer stays
        tick(0, 1, 0, 0, 1, 0, 1);
        check("edit_beats_move", 8'(LED), 8'h04);
        tick(0, 0, 0, 0, 0, 0, 1);

        // Gating: edit disabled
        tick(0, 1, 0, 0, 0, 0, 0);
        check("gated_edit", {edit_hour, edit_min, edit_sec, edit_msec}, 8'h00);
        check("gated_led", 8'(LED), 8'h00);
        tick(0, 0, 0, 0, 0, 0, 0);

        // btn_r and btn_l together in STOP: run wins, no clear
        tick(0, 0, 0, 1, 1, 1, 0);
        check("rl_run", 8'(run_stop), 8'h01);
        check("rl_no_clear", 8'(clear), 8'h00);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("rl_no_late_clear", 8'(clear), 8'h00);

        // Random levels against the model
        ru = 0; rd = 0; rr = 0; rl = 0; rws = 0; ree = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) ru = !ru;
            if ($urandom_range(3) == 0) rd = !rd;
            if ($urandom_range(3) == 0) rr = !rr;
            if ($urandom_range(3) == 0) rl = !rl;
            if ($urandom_range(15) == 0) rws = !rws;
            if ($urandom_range(15) == 0) ree = !ree;
            rrs = ($urandom_range(63) == 0);
            tick(rrs, ru, rd, rr, rl, rws, ree);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
